// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator request scheduler and its ALU.
package calc_pkg;

  localparam int DW_DEFAULT = 5;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'b00;
  localparam op_t OP_SUB = 2'b01;
  localparam op_t OP_MUL = 2'b10;
  localparam op_t OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational signed ALU: operands sign-extended to 2*DW so every result is exact.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  op_t             op,
  output logic [2*DW-1:0] result,
  output logic            divz
);

  logic signed [2*DW-1:0] a_x;
  logic signed [2*DW-1:0] b_x;

  assign a_x  = {{DW{a[DW-1]}}, a};
  assign b_x  = {{DW{b[DW-1]}}, b};
  assign divz = (op == OP_DIV) && (b == '0);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a_x + b_x;
      OP_SUB:  result = a_x - b_x;
      OP_MUL:  result = a_x * b_x;
      default: if (!divz) result = a_x / b_x;
    endcase
  end

endmodule

// File: rtl/calc_req_sched.sv
// Round-robin scheduler for two requesters sharing one calc_alu; registered, ID-tagged response.
// Optional feature macro: CALC_DIVZ_ERR_EN adds the rsp_err divide-by-zero flag.
module calc_req_sched
  import calc_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*DW-1:0] req_a,
  input  logic [2*DW-1:0] req_b,
  input  logic [3:0]      req_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_data,
  output logic            rsp_id
`ifdef CALC_DIVZ_ERR_EN
  ,
  output logic            rsp_err
`endif
);

  localparam int RW = 2 * DW;

  state_t          state, next_state;
  logic            prio_ptr;
  logic            grant;
  logic            accept;
  logic [DW-1:0]   a_q, b_q;
  op_t             op_q;
  logic            id_q;
  logic [RW-1:0]   alu_result;
  logic            alu_divz;

  // Grant depends only on req_valid and prio_ptr; it is used only while IDLE.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    accept     = 1'b0;
    grant      = prio_ptr;
    if (req_valid == 2'b01)      grant = 1'b0;
    else if (req_valid == 2'b10) grant = 1'b1;

    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          accept           = 1'b1;
          req_ready[grant] = 1'b1;
          next_state       = ST_EXEC;
        end
      end
      ST_EXEC: next_state = ST_RESP;
      ST_RESP: if (rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prio_ptr  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) prio_ptr <= ~grant;
      if (state == ST_EXEC) begin
        rsp_valid <= 1'b1;
        rsp_data  <= alu_divz ? '0 : alu_result;
        rsp_id    <= id_q;
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef CALC_DIVZ_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                rsp_err <= 1'b0;
    else if (state == ST_EXEC) rsp_err <= alu_divz;
  end
`endif

  // NOTE: operand capture registers carry no reset; they are only read in EXEC after a fresh accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= grant ? req_a[2*DW-1:DW] : req_a[DW-1:0];
      b_q  <= grant ? req_b[2*DW-1:DW] : req_b[DW-1:0];
      op_q <= grant ? req_op[3:2] : req_op[1:0];
      id_q <= grant;
    end
  end

  calc_alu #(.DW(DW)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .divz   (alu_divz)
  );

endmodule

// File: tb/tb_calc_req_sched.sv
// Self-checking bench for calc_req_sched: transaction-level model, directed cases, random traffic.
module tb_calc_req_sched;

  localparam int DW = 5;
  localparam int RW = 2 * DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [2*DW-1:0] req_a = '0;
  logic [2*DW-1:0] req_b = '0;
  logic [3:0]      req_op = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [RW-1:0]   rsp_data;
  logic            rsp_id;
`ifdef CALC_DIVZ_ERR_EN
  logic            rsp_err;
`endif

  always #5 clk = ~clk;

  calc_req_sched #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef CALC_DIVZ_ERR_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Requester-side pending requests, held stable until accepted.
  bit       pv[2];
  int       pa[2];
  int       pb[2];
  bit [1:0] pop[2];

  // Transaction-level model of the scheduler.
  bit     m_busy;
  int     m_age;
  longint m_exp;
  bit     m_id;
  bit     m_divz;
  bit     m_ptr;
  bit     acc, acc_id, done;
  longint last_data;
  bit     last_id;
  bit     last_err;
  int     n_rsp;
  bit     grants[$];

  function automatic longint ref_calc(input int a, input int b, input bit [1:0] op, output bit dz);
    dz = 1'b0;
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a * b;
      default: begin
        if (b == 0) begin
          dz = 1'b1;
          return 0;
        end
        return a / b;
      end
    endcase
  endfunction

  task automatic drive();
    req_valid = rst_n ? {pv[1], pv[0]} : 2'b00;
    req_a     = {pa[1][DW-1:0], pa[0][DW-1:0]};
    req_b     = {pb[1][DW-1:0], pb[0][DW-1:0]};
    req_op    = {pop[1], pop[0]};
  endtask

  task automatic sample();
    logic [1:0] exp_ready;
    bit         gid;
    bit         exp_rv;
    exp_ready = '0;
    acc       = 1'b0;
    done      = 1'b0;
    if (!m_busy && req_valid != 2'b00) begin
      gid            = (req_valid == 2'b11) ? m_ptr : req_valid[1];
      exp_ready[gid] = 1'b1;
      acc            = 1'b1;
      acc_id         = gid;
    end
    check("req_ready", req_ready, exp_ready);
    exp_rv = m_busy && (m_age >= 2);
    check("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      check("rsp_data", $signed(rsp_data), m_exp);
      check("rsp_id", rsp_id, m_id);
`ifdef CALC_DIVZ_ERR_EN
      check("rsp_err", rsp_err, m_divz);
      last_err = rsp_err;
`endif
      done = rsp_ready;
      if (done) begin
        last_data = $signed(rsp_data);
        last_id   = rsp_id;
        n_rsp++;
      end
    end
  endtask

  task automatic advance();
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 1'b0;
    end else begin
      if (m_busy) m_age++;
      if (done) m_busy = 1'b0;
      if (acc) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_exp  = ref_calc(pa[acc_id], pb[acc_id], pop[acc_id], m_divz);
        m_id   = acc_id;
        m_ptr  = ~acc_id;
        pv[acc_id] = 1'b0;
        grants.push_back(acc_id);
      end
    end
  endtask

  // One clock cycle: drive, check mid-cycle, then update the model just after the edge.
  task automatic step();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic set_req(input int i, input int a, input int b, input bit [1:0] op);
    pv[i]  = 1'b1;
    pa[i]  = a;
    pb[i]  = b;
    pop[i] = op;
  endtask

  task automatic rand_req(input int i);
    int b;
    b = int'($urandom_range(0, 31)) - 16;
    if ($urandom_range(0, 7) == 0) b = 0;
    set_req(i, int'($urandom_range(0, 31)) - 16, b, 2'($urandom_range(0, 3)));
  endtask

  task automatic run_until_idle(input int max_cycles);
    int k = 0;
    while ((m_busy || pv[0] || pv[1]) && k < max_cycles) begin
      step();
      k++;
    end
    check("drain_within_bound", (m_busy || pv[0] || pv[1]), 0);
  endtask

  task automatic check_reset_vals();
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id", rsp_id, 0);
`ifdef CALC_DIVZ_ERR_EN
    check("reset_rsp_err", rsp_err, 0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    check_reset_vals();
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    rsp_ready = 1'b1;
    do_reset();

    // Directed arithmetic with literal result pins.
    set_req(0, 7, -3, 2'b00);   run_until_idle(20);
    check("add_7_m3", last_data, 4);
    check("add_id", last_id, 0);
    set_req(1, -16, -16, 2'b10); run_until_idle(20);
    check("mul_m16_m16", last_data, 256);
    check("mul_id", last_id, 1);
    set_req(0, -16, -1, 2'b11);  run_until_idle(20);
    check("div_m16_m1", last_data, 16);
    set_req(1, -7, 2, 2'b11);    run_until_idle(20);
    check("div_m7_2", last_data, -3);
    set_req(0, 5, 0, 2'b11);     run_until_idle(20);
    check("div_by_zero", last_data, 0);
`ifdef CALC_DIVZ_ERR_EN
    check("divz_err_set", last_err, 1);
`endif
    set_req(0, 5, 1, 2'b11);     run_until_idle(20);
    check("div_5_1", last_data, 5);
`ifdef CALC_DIVZ_ERR_EN
    check("divz_err_clear", last_err, 0);
`endif

    // Arbitration from reset with both requesters always valid.
    do_reset();
    grants.delete();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 2; i++) if (!pv[i]) rand_req(i);
      step();
    end
    run_until_idle(40);
    check("arb_grant0", grants[0], 0);
    check("arb_grant1", grants[1], 1);
    check("arb_grant2", grants[2], 0);
    check("arb_grant3", grants[3], 1);

    // Backpressure: hold the response for 5 cycles with the other requester waiting.
    set_req(0, 3, 4, 2'b10);
    begin
      int k = 0;
      while (!(m_busy && m_age >= 2) && k < 10) begin
        step();
        k++;
      end
      check("bp_reach_resp", (m_busy && m_age >= 2), 1);
    end
    rsp_ready = 1'b0;
    set_req(1, 2, 2, 2'b01);
    base = n_rsp;
    for (int c = 0; c < 5; c++) step();
    check("bp_no_rsp_while_stalled", n_rsp, base);
    rsp_ready = 1'b1;
    run_until_idle(20);
    check("bp_rsp_count", n_rsp, base + 2);

    // Reset during EXEC: the in-flight request is dropped and the pointer returns to 0.
    do_reset();
    set_req(0, 1, 1, 2'b00);
    step();                      // accept requester 0; pointer now favours 1
    check("mid_accepted", m_busy, 1);
    rst_n = 1'b0;
    step();                      // EXEC cycle with reset asserted
    rst_n = 1'b1;
    check_reset_vals();
    base = n_rsp;
    set_req(0, 2, 3, 2'b00);
    set_req(1, 4, 5, 2'b00);
    grants.delete();
    step();
    check("mid_grant_after_reset", grants[0], 0);
    run_until_idle(30);
    check("mid_rsp_count", n_rsp, base + 2);

    // Random traffic with random backpressure and occasional resets.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) if (!pv[i] && $urandom_range(0, 1) == 1) rand_req(i);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    run_until_idle(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_req_sched.md
# calc_req_sched

Request scheduler and sequencer for the shared signed calculator ALU. Two independent requesters submit (A, B, op) transactions over valid/ready handshakes; the block arbitrates round-robin, captures operands, drives one combinational ALU instance, and returns a registered, ID-tagged result on a single response channel with backpressure. It sits between the operator front-ends (keypad decoder, test host) and the arithmetic datapath.

## Interface
- DW, 5, operand width in bits (signed, two's complement)
- RW, 2*DW (10), result width in bits; derived, not overridden
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester accept, one-hot or zero
- req_a  in  2*DW  operand A, requester i in bits [i*DW +: DW]
- req_b  in  2*DW  operand B, same packing
- req_op  in  4  op code, requester i in bits [i*2 +: 2]: 00 add, 01 sub, 10 mul, 11 div
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  RW  signed result
- rsp_id  out  1  requester index that issued the response
- rsp_err  out  1  divide-by-zero flag (only with CALC_DIVZ_ERR_EN)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant = requester with valid set; if both are valid, grant goes to prio_ptr. req_ready[grant] = 1 combinationally, other bit 0. On handshake, latch A, B, op, id; prio_ptr <= ~id; go to EXEC. No valid: stay in IDLE, req_ready = 0.
- EXEC: ALU evaluates latched operands; the result is registered into rsp_data/rsp_id (and rsp_err); rsp_valid <= 1; go to RESP.
- RESP: hold rsp_valid and all rsp_* stable until rsp_valid & rsp_ready, then rsp_valid <= 0 and go to IDLE. req_ready = 0 in EXEC and RESP.
- Arithmetic: operands are sign-extended to RW before the op, so every result is exact. Range check: -16*-16 = 256 and -16/-1 = 16 both fit. Division truncates toward zero (-7/2 = -3). Division with B = 0 yields 0.
- Requesters hold A/B/op stable while valid until ready. The block never drops an accepted request.
- Reset (any state, including mid-transaction): state IDLE, req_ready 0, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, prio_ptr 0. Any in-flight transaction is discarded.

## Timing
- Accept in cycle N (IDLE). rsp_valid rises at the edge ending cycle N+1, so it is first visible in cycle N+2.
- Zero-stall throughput: one transaction per 3 cycles (IDLE, EXEC, RESP with rsp_ready high).
- rsp_ready high during the first RESP cycle: the response completes in that cycle, and the next accept can occur in the following IDLE cycle.
- req_ready depends combinationally on req_valid and prio_ptr only. There is no path from req_* inputs to rsp_*.

## Configuration
- CALC_DIVZ_ERR_EN defined:
  - rsp_err port exists.
  - rsp_err = 1 with rsp_data = 0 when op = 11 and B = 0; otherwise rsp_err = 0.
  - rsp_err is registered and held with the response.
- Undefined: no rsp_err port or register; divide-by-zero silently returns 0.

## Structure
- Package calc_pkg:
  - op-code constants OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - the 2-bit op typedef
  - FSM state typedef
  - DW default
- Sub-module calc_alu: purely combinational, with inputs a, b, op and outputs result [RW] and divz. It is instantiated once; the scheduler owns all registers.

## Test plan
- Single add: req0 A=7, B=-3, op=00; rsp_ready=1 → rsp_valid in cycle N+2, rsp_data=4, rsp_id=0.
- Full-range multiply and divide: A=-16, B=-16, op=10 → 256. A=-16, B=-1, op=11 → 16. A=-7, B=2, op=11 → -3.
- Arbitration: both requesters valid continuously, from reset → grants alternate 0, 1, 0, 1. The non-granted requester's request stays pending and unchanged until accepted.
- Backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_* held stable, req_ready=0 throughout. Release → single response, then next accept.
- Divide by zero: A=5, B=0, op=11 → rsp_data=0. With CALC_DIVZ_ERR_EN, rsp_err=1; a following 5/1 returns rsp_err=0.
- Reset mid-transaction: assert rst_n=0 in EXEC → next cycle IDLE with all outputs at reset values. The discarded request produces no response, and prio_ptr=0.
